// File: rtl/spi_reg_slave.sv
// spi_reg_slave
//   SPI mode 0 slave that gives an external MCU burst read/write access to an
//   on-FPGA register space. The first ADDR_W bits of a frame form the command
//   word (MSB = 1 for read, low ADDR_W-1 bits = start address). Every further
//   DATA_W bits form a data word, and the address auto-increments after each
//   word, wrapping modulo 2^(ADDR_W-1).
//
// Ports
//   clk, reset          system clock (posedge); asynchronous active-low reset
//   SPI_SCK/CS/MOSI     raw SPI inputs, asynchronous to clk
//   SPI_MISO            slave-out data, MSB first, changes on SCK falling edges
//   wr_en/addr/data     register write strobe with address and data
//   rd_en/addr          register read request; rd_data is returned one clk later
//   busy                synchronised chip select active
//   frame_done          one-cycle pulse when the synchronised CS deasserts
//   fsm_state           current FSM state (0 idle, 1 command, 2 data)
//
// Strobe semantics: wr_en and rd_en are single-cycle strobes with no
// back-pressure. The address and data ports are valid in the strobe cycle and
// keep their value until the next strobe. The register file must return
// rd_data in the clk cycle that follows rd_en.

module spi_reg_slave #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 8,
    parameter int SYNC_STAGES  = 2,
    parameter bit CS_ACTIVE_HI = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              SPI_SCK,
    input  logic              SPI_CS,
    input  logic              SPI_MOSI,
    output logic              SPI_MISO,
    output logic              wr_en,
    output logic [ADDR_W-2:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              rd_en,
    output logic [ADDR_W-2:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              frame_done,
    output logic [1:0]        fsm_state
);

    localparam int   MAX_W       = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int   CNT_W       = $clog2(MAX_W);
    localparam logic CS_IDLE_LVL = logic'(!CS_ACTIVE_HI);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync, flush;
    logic                   sck_rise, sck_fall, cs_act, mosi_bit;
    logic                   cs_act_q, armed, rw, load_pend;
    logic [CNT_W-1:0]       bit_cnt;
    logic [ADDR_W-2:0]      cmd_sr, addr;
    logic [DATA_W-2:0]      data_sr;
    logic [DATA_W-1:0]      tx_sr;
    logic [ADDR_W-1:0]      cmd_word;
    logic [DATA_W-1:0]      data_word;
    logic                   cmd_last, word_last;

    assign sck_rise  = sck_sync[SYNC_STAGES-2] & ~sck_sync[SYNC_STAGES-1];
    assign sck_fall  = ~sck_sync[SYNC_STAGES-2] & sck_sync[SYNC_STAGES-1];
    assign cs_act    = (cs_sync[SYNC_STAGES-1] == logic'(CS_ACTIVE_HI));
    // MOSI was set up half an SCK period before the rising edge.
    // The oldest stage therefore already holds the bit being sampled.
    assign mosi_bit  = mosi_sync[SYNC_STAGES-1];
    assign cmd_word  = {cmd_sr, mosi_bit};
    assign data_word = {data_sr, mosi_bit};
    assign cmd_last  = (bit_cnt == CNT_W'(ADDR_W - 1));
    assign word_last = (bit_cnt == CNT_W'(DATA_W - 1));

    assign SPI_MISO  = (state_q == ST_DATA) && rw && tx_sr[DATA_W-1];
    assign fsm_state = state_q;

    // Synchronisers. The CS chain resets to its inactive level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sck_sync  <= '0;
            mosi_sync <= '0;
            cs_sync   <= {SYNC_STAGES{CS_IDLE_LVL}};
            flush     <= '0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SPI_SCK};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], SPI_MOSI};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], SPI_CS};
            flush     <= {flush[SYNC_STAGES-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (armed) state_d = ST_CMD;
            ST_CMD:  if (sck_rise && cmd_last) state_d = ST_DATA;
            ST_DATA: state_d = ST_DATA;
            default: state_d = ST_IDLE;
        endcase
        // CS going inactive overrides any SCK edge seen in the same cycle.
        if (!cs_act) state_d = ST_IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            rd_en      <= 1'b0;
            rd_addr    <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            cs_act_q   <= 1'b0;
            armed      <= 1'b0;
            rw         <= 1'b0;
            load_pend  <= 1'b0;
            bit_cnt    <= '0;
            cmd_sr     <= '0;
            addr       <= '0;
            data_sr    <= '0;
            tx_sr      <= '0;
        end else begin
            wr_en      <= 1'b0;
            rd_en      <= 1'b0;
            load_pend  <= rd_en;
            busy       <= cs_act;
            cs_act_q   <= cs_act;
            frame_done <= cs_act_q & ~cs_act;
            // A frame may only start after CS has been seen inactive through a
            // flushed synchroniser. So CS that is held across a reset release
            // does not start a frame halfway through.
            if (flush[SYNC_STAGES-1] && !cs_act) armed <= 1'b1;

            if (!cs_act) begin
                bit_cnt <= '0;
            end else begin
                case (state_q)
                    ST_CMD: begin
                        if (sck_rise) begin
                            cmd_sr <= cmd_word[ADDR_W-2:0];
                            if (cmd_last) begin
                                bit_cnt <= '0;
                                rw      <= cmd_sr[ADDR_W-2];
                                addr    <= cmd_word[ADDR_W-2:0];
                                if (cmd_sr[ADDR_W-2]) begin
                                    rd_en   <= 1'b1;
                                    rd_addr <= cmd_word[ADDR_W-2:0];
                                end
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                    end
                    ST_DATA: begin
                        if (sck_rise) begin
                            data_sr <= data_word[DATA_W-2:0];
                            if (word_last) begin
                                bit_cnt <= '0;
                                addr    <= addr + (ADDR_W-1)'(1);
                                if (rw) begin
                                    // Prefetch the next word. The last one in a burst is unused.
                                    rd_en   <= 1'b1;
                                    rd_addr <= addr + (ADDR_W-1)'(1);
                                end else begin
                                    wr_en   <= 1'b1;
                                    wr_addr <= addr;
                                    wr_data <= data_word;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                        // The falling edge right after a word load must keep the
                        // freshly loaded MSB, so bit 0 of a word never shifts.
                        if (sck_fall && rw && (bit_cnt != '0))
                            tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
                    end
                    default: bit_cnt <= '0;
                endcase
            end

            if (load_pend) tx_sr <= rd_data;
        end
    end

endmodule

// File: tb/tb_spi_reg_slave.sv
module tb_spi_reg_slave;

    localparam int HALF = 8;   // clk cycles per SCK half period

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n = 1'b0;

    // shared SPI pins, separate chip selects
    logic sck = 1'b0, mosi = 1'b0, cs0 = 1'b0, cs1 = 1'b1;

    // DUT 0: default parameters, CS active high
    logic        miso0, wr_en0, rd_en0, busy0, fd0;
    logic [6:0]  wr_addr0, rd_addr0;
    logic [7:0]  wr_data0;
    logic [7:0]  rd_data0 = 8'h00;
    logic [1:0]  st0;

    // DUT 1: 16-bit data, CS active low
    logic        miso1, wr_en1, rd_en1, busy1, fd1;
    logic [6:0]  wr_addr1, rd_addr1;
    logic [15:0] wr_data1;
    logic [15:0] rd_data1 = 16'h0000;
    logic [1:0]  st1;

    spi_reg_slave u_dut0 (
        .clk(clk), .reset(rst_n), .SPI_SCK(sck), .SPI_CS(cs0), .SPI_MOSI(mosi),
        .SPI_MISO(miso0), .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0),
        .rd_en(rd_en0), .rd_addr(rd_addr0), .rd_data(rd_data0), .busy(busy0),
        .frame_done(fd0), .fsm_state(st0)
    );

    spi_reg_slave #(.ADDR_W(8), .DATA_W(16), .SYNC_STAGES(2), .CS_ACTIVE_HI(1'b0)) u_dut1 (
        .clk(clk), .reset(rst_n), .SPI_SCK(sck), .SPI_CS(cs1), .SPI_MOSI(mosi),
        .SPI_MISO(miso1), .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
        .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_data(rd_data1), .busy(busy1),
        .frame_done(fd1), .fsm_state(st1)
    );

    // register file model for reads: one-cycle latency, data = ~address
    always @(posedge clk) if (rd_en0) rd_data0 <= ~{1'b0, rd_addr0};

    // scoreboard
    int tests_run = 0;
    int fail_cnt  = 0;
    int fd0_cnt   = 0;
    logic [14:0] wr0_q[$];
    logic [22:0] wr1_q[$];
    logic [6:0]  rd0_q[$];
    logic [7:0]  miso_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (fd0) fd0_cnt++;
        if (wr_en0) begin
            chk("wr0_expected", 32'(wr0_q.size() > 0), 32'd1);
            if (wr0_q.size() > 0) chk("wr0_addr_data", 32'({wr_addr0, wr_data0}), 32'(wr0_q.pop_front()));
        end
        if (wr_en1) begin
            chk("wr1_expected", 32'(wr1_q.size() > 0), 32'd1);
            if (wr1_q.size() > 0) chk("wr1_addr_data", 32'({wr_addr1, wr_data1}), 32'(wr1_q.pop_front()));
        end
        if (rd_en0) begin
            chk("rd0_expected", 32'(rd0_q.size() > 0), 32'd1);
            if (rd0_q.size() > 0) chk("rd0_addr", 32'(rd_addr0), 32'(rd0_q.pop_front()));
        end
    end

    // driver tasks
    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic spi_bit(input int d, input logic b, output logic so);
        mosi = b;
        wclk(HALF);
        so = (d == 0) ? miso0 : miso1;
        sck = 1'b1;
        wclk(HALF);
        sck = 1'b0;
    endtask

    task automatic spi_word(input int d, input logic [15:0] w, input int n, output logic [15:0] r);
        logic b;
        r = '0;
        for (int i = n - 1; i >= 0; i--) begin
            spi_bit(d, w[i], b);
            r = {r[14:0], b};
        end
    endtask

    task automatic cs_set(input int d, input logic on);
        if (d == 0) cs0 = on;
        else        cs1 = ~on;
        wclk(6);
    endtask

    logic [15:0] r;
    int fd_before;

    initial begin
        // reset state
        wclk(3);
        chk("rst_wr_en", 32'(wr_en0), 32'd0);
        chk("rst_rd_en", 32'(rd_en0), 32'd0);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_frame_done", 32'(fd0), 32'd0);
        chk("rst_miso", 32'(miso0), 32'd0);
        chk("rst_wr_addr_data", 32'({wr_addr0, wr_data0}), 32'd0);
        chk("rst_rd_addr", 32'(rd_addr0), 32'd0);
        chk("rst_state", 32'(st0), 32'd0);
        chk("rst_busy1", 32'(busy1), 32'd0);
        chk("rst_state1", 32'(st1), 32'd0);
        rst_n = 1'b1;
        wclk(5);

        // 1: single write
        fd_before = fd0_cnt;
        wr0_q.push_back({7'h05, 8'hA5});
        cs_set(0, 1'b1);
        chk("t1_busy", 32'(busy0), 32'd1);
        spi_word(0, 16'h05, 8, r);
        spi_word(0, 16'hA5, 8, r);
        cs_set(0, 1'b0);
        wclk(6);
        chk("t1_wr_done", 32'(wr0_q.size()), 32'd0);
        chk("t1_frame_done", 32'(fd0_cnt - fd_before), 32'd1);
        chk("t1_busy_off", 32'(busy0), 32'd0);

        // 2: burst write with address wrap
        wr0_q.push_back({7'h7F, 8'h11});
        wr0_q.push_back({7'h00, 8'h22});
        wr0_q.push_back({7'h01, 8'h33});
        cs_set(0, 1'b1);
        spi_word(0, 16'h7F, 8, r);
        spi_word(0, 16'h11, 8, r);
        spi_word(0, 16'h22, 8, r);
        spi_word(0, 16'h33, 8, r);
        cs_set(0, 1'b0);
        wclk(6);
        chk("t2_wr_done", 32'(wr0_q.size()), 32'd0);

        // 3: burst read with prefetch
        rd0_q.push_back(7'h03);
        rd0_q.push_back(7'h04);
        rd0_q.push_back(7'h05);
        miso_q.push_back(8'hFC);
        miso_q.push_back(8'hFB);
        cs_set(0, 1'b1);
        spi_word(0, 16'h83, 8, r);
        spi_word(0, 16'h00, 8, r);
        chk("t3_miso_word0", 32'(r[7:0]), 32'(miso_q.pop_front()));
        spi_word(0, 16'h00, 8, r);
        chk("t3_miso_word1", 32'(r[7:0]), 32'(miso_q.pop_front()));
        cs_set(0, 1'b0);
        wclk(6);
        chk("t3_rd_done", 32'(rd0_q.size()), 32'd0);
        chk("t3_miso_idle", 32'(miso0), 32'd0);

        // 4: CS dropped mid-word, then a normal frame
        fd_before = fd0_cnt;
        cs_set(0, 1'b1);
        spi_word(0, 16'h10, 8, r);
        spi_word(0, 16'h1F, 5, r);
        cs_set(0, 1'b0);
        wclk(6);
        chk("t4_frame_done_once", 32'(fd0_cnt - fd_before), 32'd1);
        chk("t4_state_idle", 32'(st0), 32'd0);
        wr0_q.push_back({7'h06, 8'h5A});
        cs_set(0, 1'b1);
        spi_word(0, 16'h06, 8, r);
        spi_word(0, 16'h5A, 8, r);
        cs_set(0, 1'b0);
        wclk(6);
        chk("t4_next_frame", 32'(wr0_q.size()), 32'd0);

        // 5: asynchronous reset in the middle of a data word
        cs_set(0, 1'b1);
        spi_word(0, 16'h20, 8, r);
        spi_word(0, 16'h0C, 4, r);
        #3 rst_n = 1'b0;
        #1;
        chk("t5_async_busy", 32'(busy0), 32'd0);
        chk("t5_async_wr", 32'({wr_en0, wr_addr0, wr_data0}), 32'd0);
        chk("t5_async_state", 32'(st0), 32'd0);
        wclk(2);
        rst_n = 1'b1;
        wclk(4);
        spi_word(0, 16'h3C, 4, r);
        spi_word(0, 16'hFF, 8, r);
        chk("t5_no_restart", 32'(st0), 32'd0);
        cs_set(0, 1'b0);
        wclk(6);
        wr0_q.push_back({7'h21, 8'h3C});
        cs_set(0, 1'b1);
        spi_word(0, 16'h21, 8, r);
        spi_word(0, 16'h3C, 8, r);
        cs_set(0, 1'b0);
        wclk(6);
        chk("t5_after_reset", 32'(wr0_q.size()), 32'd0);

        // 6: active-low CS, 16-bit data
        wr1_q.push_back({7'h02, 16'hBEEF});
        cs_set(1, 1'b1);
        chk("t6_busy1", 32'(busy1), 32'd1);
        spi_word(1, 16'h02, 8, r);
        spi_word(1, 16'hBEEF, 16, r);
        cs_set(1, 1'b0);
        wclk(6);
        chk("t6_wr_done", 32'(wr1_q.size()), 32'd0);

        chk("end_wr0_q_empty", 32'(wr0_q.size()), 32'd0);
        chk("end_rd0_q_empty", 32'(rd0_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule
